mem_arbiter: RTL
================

# mem_arbiter

N-channel, round-robin memory arbiter and byte serializer sitting between the CPU's requesters (instruction fetch, LSB, and future clients such as a prefetcher) and the 8-bit external memory/UART bus. It accepts byte, half and word read/write requests from `NCH` channels and serializes each into single-byte bus cycles with little-endian assembly and optional sign extension. It honours `io_buffer_full` on I/O writes and aborts speculative reads on `clear`. It generalises the current two-client memory controller to a parametrised channel count with fair arbitration and per-channel flush control.

## Interface
- `NCH`, 2: number of request channels (1..8).
- `FLUSH_MASK`, {NCH{1'b1}}: bit k=1 means channel k's reads are aborted by `clear`.
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: when low, freeze the block (see Operation).
- `clear` in 1: misprediction flush.
- `req_valid` in NCH: channel k requests; held high until its `done` pulse.
- `req_addr` in NCH*32: byte address, channel k at [32k+31:32k]; stable while valid.
- `req_wr` in NCH: 1 = write, 0 = read.
- `req_size` in NCH*2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 2.
- `req_sext` in NCH: sign-extend read result.
- `req_wdata` in NCH*32: write data, low bytes used.
- `done` out NCH: one-cycle completion pulse for channel k.
- `rdata` out 32: read result, valid in the `done` cycle.
- `mem_din` in 8: bus read data, returned one cycle after its address is driven.
- `mem_dout` out 8: bus write data.
- `mem_a` out 32: bus address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART TX buffer full.

## Operation
- All outputs are registered. Reset values: `done`=0, `rdata`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, state IDLE, RR pointer 0.
- States:
  - IDLE: picks a grant.
  - RD: issues and captures bytes of a read.
  - WR: issues bytes of a write.
  - FIN: pulses `done`, then returns to IDLE.
- Arbitration runs in IDLE. The winner is the first valid channel at or after the RR pointer, cyclically. After a grant to channel k, pointer = (k+1) mod NCH. A channel whose `done` is high this cycle is excluded from arbitration.
- Byte count n = 1, 2 or 4 from `req_size`. Byte i uses address `req_addr`+i (32-bit wrap). Write byte i is `req_wdata[8i+7:8i]`.
- Read: byte i lands in `rdata[8i+7:8i]`. If `req_sext`=1, bits above 8n-1 are copies of bit 8n-1; otherwise they are zero.
- I/O: an address with bits [17:16]=2'b11 is I/O. A WR byte to I/O while `io_buffer_full`=1 is held: `mem_wr`=0 and the byte index does not advance until the flag drops. Reads ignore `io_buffer_full`.
- `clear`:
  - In RD for a channel whose `FLUSH_MASK` bit is set: go to IDLE next edge, with no `done`, `mem_wr`=0 and the RR pointer unchanged.
  - WR transfers, non-flushable channels, IDLE and FIN are unaffected.
- `rdy_in` low: every register holds and `mem_wr` is forced 0.
  - If this happens during RD, on the first cycle after `rdy_in` returns the read restarts from byte 0.
  - If it happens during WR, the transfer resumes at the held byte index. No byte is written twice.
- `rst_in` asserted mid-transfer returns all registers to reset values immediately. No `done` is produced.

## Timing
- G is the IDLE cycle in which the grant is decided. Cycles G+1..G+n drive `mem_a` = addr+0..n-1.
- Read: byte i arrives in cycle G+2+i. The last byte is captured at the end of G+n+1. `done` and `rdata` appear in G+n+2. Latency from grant to done is n+2 cycles: 3, 4 or 6.
- Write: `mem_wr`=1 in G+1..G+n, excluding I/O hold cycles. `done` appears in G+n+1, i.e. n+1 cycles plus hold cycles.
- FIN is the IDLE-eligible cycle, so back-to-back grants to a different channel are legal with one bus-idle cycle between transfers.
- `mem_wr`=0 in every cycle not listed above. `mem_a` holds its last value when idle.

## Test plan
- Ch0 reads a word at 0x100 with memory bytes 11 22 33 44 -> `done[0]` 6 cycles after grant, `rdata`=0x44332211, with 4 consecutive addresses 0x100..0x103.
- Ch1 reads a half at 0x200 with bytes 0x34 0x85 and `req_sext`=1 -> `rdata`=0xFFFF8534. With `req_sext`=0 -> 0x00008534.
- Ch0 and ch1 held valid continuously with NCH=2 -> grants alternate 0,1,0,1, and neither channel is re-granted in its own `done` cycle.
- Ch0 writes byte 0x41 to 0x30000 with `io_buffer_full` high for 5 cycles -> `mem_wr` stays 0 for those cycles, then exactly one write of 0x41, then `done[0]`.
- Word read on flushable ch1 with `clear` pulsed in cycle G+2 -> no `done[1]`, state IDLE at G+3. A concurrent ch0 request is granted in G+3.
- `rdy_in` low for 3 cycles at G+2 of a word read -> the read restarts, `rdata` is still correct, and `done` is delayed to 2+3+6 cycles after grant. `rst_in` low mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter for NCH requesters in front of the 8-bit external
//   memory / UART bus. Each byte, half or word request becomes a run of
//   single-byte bus cycles. Read bytes are assembled little-endian, with
//   optional sign extension. I/O writes wait while the UART TX buffer is
//   full. Speculative reads on flushable channels are abandoned on clear.
//
// Ports
//   clk_in, rst_in      clock (rising edge), asynchronous active-low reset
//   rdy_in              0 = freeze every register, mem_wr forced low
//   clear               misprediction flush
//   req_valid/addr/wr/size/sext/wdata
//                       per-channel request fields, channel k in slice k
//   done                one-cycle completion pulse, one bit per channel
//   rdata               read result, valid while done is high
//   mem_din             bus read data, one cycle after its address
//   mem_dout, mem_a, mem_wr
//                       bus write data, address and write strobe
//   io_buffer_full      UART TX buffer full
// ---------------------------------------------------------------------------
//   state | meaning
//   IDLE  | no transfer; arbitrate among valid channels
//   RD    | drive read addresses and capture the returning bytes
//   WR    | drive write bytes, holding on a full I/O buffer
//   FIN   | done pulse; arbitrates like IDLE, finishing channel excluded
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int             NCH        = 2,
    parameter logic [NCH-1:0] FLUSH_MASK = {NCH{1'b1}}
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH*32-1:0]   req_addr,
    input  logic [NCH-1:0]      req_wr,
    input  logic [NCH*2-1:0]    req_size,
    input  logic [NCH-1:0]      req_sext,
    input  logic [NCH*32-1:0]   req_wdata,
    output logic [NCH-1:0]      done,
    output logic [31:0]         rdata,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [31:0]         mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      n_q;
    logic            sext_q;
    logic [2:0]      idx;
    logic [31:0]     buf_q;
    logic            rd_restart;    // a freeze hit this read; start over
    logic            wr_pend;       // byte at idx reached the bus before a freeze

    logic [NCH-1:0]  cand;
    logic            any_req;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_nxt;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [1:0]      sel_size;
    logic [2:0]      sel_n;
    logic            sel_wr;
    logic            sel_sext;
    logic [2:0]      nxt_idx;
    logic [31:0]     nxt_addr;
    logic [31:0]     rd_full;
    logic [31:0]     rd_ext;

    function automatic logic [7:0] lane(input logic [31:0] d, input logic [2:0] i);
        case (i)
            3'd0:    lane = d[7:0];
            3'd1:    lane = d[15:8];
            3'd2:    lane = d[23:16];
            default: lane = d[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] d, input logic [2:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = d;
        case (i)
            3'd0:    r[7:0]   = b;
            3'd1:    r[15:8]  = b;
            3'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    // First eligible channel at or after the pointer, wrapping. A channel
    // in its own done cycle is still asserting valid and must not re-win.
    always_comb begin
        int j;
        j       = 0;
        any_req = 1'b0;
        win     = '0;
        cand    = req_valid & ~done;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) j = j - NCH;
            if (!any_req && cand[j]) begin
                any_req = 1'b1;
                win     = PW'(j);
            end
        end
        ptr_nxt = (int'(win) == NCH - 1) ? '0 : win + PW'(1);
    end

    always_comb begin
        sel_addr  = req_addr[32*win +: 32];
        sel_wdata = req_wdata[32*win +: 32];
        sel_size  = req_size[2*win +: 2];
        sel_wr    = req_wr[win];
        sel_sext  = req_sext[win];
        case (sel_size)
            2'd0:    sel_n = 3'd1;
            2'd1:    sel_n = 3'd2;
            default: sel_n = 3'd4;
        endcase
    end

    always_comb begin
        nxt_idx  = idx + 3'd1;
        nxt_addr = addr_q + {29'd0, nxt_idx};
        // Last byte is taken straight from the bus into the result.
        rd_full  = put_lane(buf_q, n_q - 3'd1, mem_din);
        case (n_q)
            3'd1:    rd_ext = sext_q ? {{24{rd_full[7]}}, rd_full[7:0]}
                                     : {24'd0, rd_full[7:0]};
            3'd2:    rd_ext = sext_q ? {{16{rd_full[15]}}, rd_full[15:0]}
                                     : {16'd0, rd_full[15:0]};
            default: rd_ext = rd_full;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= 3'd1;
            sext_q     <= 1'b0;
            idx        <= 3'd0;
            buf_q      <= '0;
            rd_restart <= 1'b0;
            wr_pend    <= 1'b0;
            done       <= '0;
            rdata      <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else if (!rdy_in) begin
            mem_wr <= 1'b0;
            if (state == RD) rd_restart <= 1'b1;
            if (state == WR && mem_wr) wr_pend <= 1'b1;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done   <= '0;
                    mem_wr <= 1'b0;
                    if (any_req) begin
                        gnt_q      <= win;
                        ptr        <= ptr_nxt;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        n_q        <= sel_n;
                        sext_q     <= sel_sext;
                        idx        <= 3'd0;
                        buf_q      <= '0;
                        rd_restart <= 1'b0;
                        wr_pend    <= 1'b0;
                        mem_a      <= sel_addr;
                        if (sel_wr) begin
                            state    <= WR;
                            mem_dout <= sel_wdata[7:0];
                            mem_wr   <= !(is_io(sel_addr) && io_buffer_full);
                        end else begin
                            state <= RD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                // idx counts RD cycles: address idx is on the bus while
                // byte idx-1 is on mem_din.
                RD: begin
                    if (clear && FLUSH_MASK[gnt_q]) begin
                        state      <= IDLE;
                        rd_restart <= 1'b0;
                    end else if (rd_restart) begin
                        rd_restart <= 1'b0;
                        idx        <= 3'd0;
                        buf_q      <= '0;
                        mem_a      <= addr_q;
                    end else if (idx == n_q) begin
                        state       <= FIN;
                        done[gnt_q] <= 1'b1;
                        rdata       <= rd_ext;
                    end else begin
                        if (idx != 3'd0) buf_q <= put_lane(buf_q, idx - 3'd1, mem_din);
                        if (nxt_idx < n_q) mem_a <= nxt_addr;
                        idx <= nxt_idx;
                    end
                end

                // mem_wr high (or wr_pend) means byte idx has been written.
                WR: begin
                    if (mem_wr || wr_pend) begin
                        wr_pend <= 1'b0;
                        if (nxt_idx == n_q) begin
                            state       <= FIN;
                            done[gnt_q] <= 1'b1;
                            mem_wr      <= 1'b0;
                        end else begin
                            idx      <= nxt_idx;
                            mem_a    <= nxt_addr;
                            mem_dout <= lane(wdata_q, nxt_idx);
                            mem_wr   <= !(is_io(nxt_addr) && io_buffer_full);
                        end
                    end else begin
                        mem_wr <= !(is_io(mem_a) && io_buffer_full);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
